address_generator_ctrl: RTL and testbench
=========================================

// Module: address_generator_ctrl
// PURPOSE
//  Layer sequencer for the neural accelerator datapath, upstream of the weight ROM, neuron RAM and MAC core.
//  Holds a small instruction RAM with one word per layer: neuron count and input count.
//  Steps an instruction pointer and keeps per-layer base registers (neuron read, neuron write, weight).
//  Emits one read/weight/write address triple per clock for the MAC, plus neuron and layer end strobes.
// PARAMETERS
//  AW        8   width of every address output and base register
//  IW        4   instruction-pointer / instruction-RAM address width
//  IP_DEPTH  16  number of instruction words (2**IW)
// PORTS
//  clk               in   1   single clock, all state on rising edge
//  reset             in   1   synchronous, active-high; clears all state except instruction RAM contents
//  start             in   1   one-cycle pulse; honoured only in IDLE or HALT
//  instr_we          in   1   instruction RAM write enable
//  instr_waddr       in   IW  instruction RAM write address
//  instr_wdata       in   16  instruction word: [15:8]=n_out (neurons), [7:0]=n_in (inputs/neuron)
//  neuro_read_addr   out  AW  neuron RAM read address (MAC input operand)
//  weight_read_addr  out  AW  weight ROM address
//  neuro_write_addr  out  AW  neuron RAM address of the neuron being accumulated
//  addr_valid        out  1   addresses valid (high only in RUN)
//  neuron_finished   out  1   high on the last input cycle of each neuron
//  layer_finished    out  1   high on the last input cycle of the layer's last neuron
//  alu_rst           out  1   MAC clear; high whenever not in RUN
//  busy              out  1   high in FETCH or RUN
//  done              out  1   high in HALT
//  ip                out  IW  current instruction pointer
// BEHAVIOUR
//  - Instruction RAM: synchronous write on instr_we, combinational read at ip. Not cleared by reset.
//    Same-cycle write and fetch of one address: the fetch gets the old word.
//  - FSM states IDLE, FETCH, RUN, HALT. Reset -> IDLE, ip=0, all bases=0, all outputs 0.
//  - IDLE/HALT + start -> FETCH.
//    Start also sets ip=0, rd_base=0, wt_base=0, wr_base=n_in of instr[0].
//  - FETCH (1 cycle): latch instr[ip].
//    If n_in==0 or n_out==0 -> HALT, else -> RUN with counters i=0, j=0.
//  - RUN, one cycle per (j,i), i inner; layer takes n_in*n_out cycles:
//    neuro_read_addr=rd_base+i; weight_read_addr=wt_base+j*n_in+i (running counter);
//    neuro_write_addr=wr_base+j.
//  - neuron_finished = (i==n_in-1). layer_finished = neuron_finished & (j==n_out-1).
//    Both are combinational with the same cycle's addresses.
//  - On layer_finished: rd_base<=wr_base; wr_base<=wr_base+n_out; wt_base<=last weight addr+1.
//    If ip==IP_DEPTH-1 -> HALT, else ip<=ip+1 -> FETCH.
//  - Outside RUN: all address outputs and strobes are 0, and alu_rst=1.
//  - All address arithmetic is modulo 2**AW (silent wrap).
//  - start while busy is ignored. start and reset together: reset wins.
//  - Reset mid-RUN aborts to IDLE next edge, outputs 0. The next start replays from ip=0 identically.
// TESTING
//  1. reset -> addr_valid=0, busy=0, done=0, alu_rst=1, ip=0, all addresses 0.
//  2. instr0=0x0203, instr1=0x0000, start -> FETCH, then 6 RUN cycles:
//     read 0,1,2,0,1,2; weight 0..5; write 3,3,3,4,4,4;
//     neuron_finished on cycles 3 and 6; layer_finished on 6; then FETCH -> done=1.
//  3. instr0=0x0203, instr1=0x0102, instr2=0 -> layer 2 is read 3,4, weight 6,7, write 5,5,
//     layer_finished on its 2nd cycle; then HALT.
//  4. Reset asserted on RUN cycle 4 of test 2 -> next cycle IDLE, outputs 0;
//     start -> exact test 2 sequence.
//  5. start pulsed during RUN -> ignored. instr0=0x0000, start -> FETCH then HALT, addr_valid never 1.
//  6. All 16 instructions 0x0101 -> 16 single-cycle layers, read/write chain 0->1->2...;
//     ip stops at 15, then HALT.

Source files
------------

// File: rtl/address_generator_ctrl_if.sv
// -----------------------------------------------------------------------------
// address_generator_ctrl_if
//   Bus bundle between the layer sequencer and its controller / datapath.
//   master : drives start and the instruction-RAM write port, observes the
//            address triple, strobes and status.
//   slave  : the sequencer itself.
//   Signals
//     start, instr_we, instr_waddr[IW], instr_wdata[16]      master -> slave
//     neuro_read_addr, weight_read_addr, neuro_write_addr[AW] slave -> master
//     addr_valid, neuron_finished, layer_finished, alu_rst,
//     busy, done, ip[IW]                                      slave -> master
// -----------------------------------------------------------------------------
interface address_generator_ctrl_if #(
   parameter int AW = 8,
   parameter int IW = 4
);
   logic          start;
   logic          instr_we;
   logic [IW-1:0] instr_waddr;
   logic [15:0]   instr_wdata;
   logic [AW-1:0] neuro_read_addr;
   logic [AW-1:0] weight_read_addr;
   logic [AW-1:0] neuro_write_addr;
   logic          addr_valid;
   logic          neuron_finished;
   logic          layer_finished;
   logic          alu_rst;
   logic          busy;
   logic          done;
   logic [IW-1:0] ip;

   modport master (
      output start, instr_we, instr_waddr, instr_wdata,
      input  neuro_read_addr, weight_read_addr, neuro_write_addr,
             addr_valid, neuron_finished, layer_finished, alu_rst, busy, done, ip
   );

   modport slave (
      input  start, instr_we, instr_waddr, instr_wdata,
      output neuro_read_addr, weight_read_addr, neuro_write_addr,
             addr_valid, neuron_finished, layer_finished, alu_rst, busy, done, ip
   );
endinterface

// File: rtl/address_generator_ctrl.sv
// -----------------------------------------------------------------------------
// address_generator_ctrl
//   Layer sequencer for the neural accelerator. A small instruction RAM holds
//   one word per layer ([15:8] neuron count, [7:0] inputs per neuron). After
//   start, each layer is fetched and then swept one (neuron, input) pair per
//   clock, producing neuron-read / weight / neuron-write addresses for the MAC.
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high; clears everything but the instr RAM
//     bus    : address_generator_ctrl_if.slave (start, instr write port,
//              address triple, strobes, alu_rst, busy, done, ip)
// -----------------------------------------------------------------------------
module address_generator_ctrl #(
   parameter int AW       = 8,
   parameter int IW       = 4,
   parameter int IP_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   address_generator_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, FETCH, RUN, HALT} state_t;

   state_t        state, state_nxt;
   logic [15:0]   instr_mem [IP_DEPTH];
   logic [15:0]   cur_instr;
   logic [IW-1:0] ip_r;
   logic [7:0]    n_in_r, n_out_r;
   logic [7:0]    i_cnt, j_cnt;
   logic [AW-1:0] rd_base, wr_base, wt_ptr;
   logic          in_run, idle_like, last_ip;
   logic          neuron_fin, layer_fin;

   // NOTE: the instruction RAM is deliberately left out of reset so a program
   // loaded once survives a pipeline reset; it also maps onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (bus.instr_we)
         instr_mem[bus.instr_waddr] <= bus.instr_wdata;
   end

   // Combinational read: a same-edge write is not visible to this fetch.
   assign cur_instr  = instr_mem[ip_r];

   assign in_run     = (state == RUN);
   assign idle_like  = (state == IDLE) || (state == HALT);
   assign last_ip    = (ip_r == IW'(IP_DEPTH - 1));
   assign neuron_fin = in_run && (i_cnt == n_in_r - 8'd1);
   assign layer_fin  = neuron_fin && (j_cnt == n_out_r - 8'd1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HALT: if (bus.start) state_nxt = FETCH;
         FETCH:      state_nxt = (cur_instr[7:0] == 8'd0 || cur_instr[15:8] == 8'd0) ? HALT : RUN;
         RUN:        if (layer_fin) state_nxt = last_ip ? HALT : FETCH;
         default:    state_nxt = IDLE;
      endcase
   end

   // Datapath: pointer, per-layer bases and the (j, i) sweep counters.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ip_r    <= '0;
         rd_base <= '0;
         wr_base <= '0;
         wt_ptr  <= '0;
         n_in_r  <= '0;
         n_out_r <= '0;
         i_cnt   <= '0;
         j_cnt   <= '0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (bus.start) begin
                  ip_r    <= '0;
                  rd_base <= '0;
                  wt_ptr  <= '0;
                  // Layer 0 writes its outputs right after its inputs.
                  wr_base <= AW'(instr_mem[0][7:0]);
               end
            end
            FETCH: begin
               n_in_r  <= cur_instr[7:0];
               n_out_r <= cur_instr[15:8];
               i_cnt   <= '0;
               j_cnt   <= '0;
            end
            RUN: begin
               // The weight pointer just keeps running; at layer end it already
               // sits one past the layer's last weight.
               wt_ptr <= wt_ptr + 1'b1;
               if (neuron_fin) begin
                  i_cnt <= '0;
                  j_cnt <= j_cnt + 8'd1;
               end else begin
                  i_cnt <= i_cnt + 8'd1;
               end
               if (layer_fin) begin
                  rd_base <= wr_base;
                  wr_base <= wr_base + AW'(n_out_r);
                  if (!last_ip) ip_r <= ip_r + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced to zero outside RUN so the MAC sees clean idle values.
   assign bus.neuro_read_addr  = in_run ? rd_base + AW'(i_cnt) : '0;
   assign bus.weight_read_addr = in_run ? wt_ptr               : '0;
   assign bus.neuro_write_addr = in_run ? wr_base + AW'(j_cnt) : '0;
   assign bus.addr_valid       = in_run;
   assign bus.neuron_finished  = neuron_fin;
   assign bus.layer_finished   = layer_fin;
   assign bus.alu_rst          = !in_run;
   assign bus.busy             = (state == FETCH) || in_run;
   assign bus.done             = (state == HALT);
   assign bus.ip               = ip_r;

endmodule

// File: tb/tb_address_generator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_address_generator_ctrl
//   Loads programs into the sequencer, starts them, and compares every cycle
//   against an expected trace generated from the layer rules (nested loops
//   over layers, neurons and inputs).
// -----------------------------------------------------------------------------
module tb_address_generator_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   address_generator_ctrl_if #(.AW(8), .IW(4)) bus ();

   address_generator_ctrl #(.AW(8), .IW(4), .IP_DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] prog [16];
   logic [33:0] exp_q [$];

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // {valid, nf, lf, alu_rst, busy, done, ip[4], read[8], weight[8], write[8]}
   function automatic logic [33:0] rec(bit v, bit nf, bit lf, bit ar, bit bz, bit dn,
                                       bit [3:0] ip, bit [7:0] rd, bit [7:0] wt, bit [7:0] wr);
      return {v, nf, lf, ar, bz, dn, ip, rd, wt, wr};
   endfunction

   function automatic logic [33:0] observe();
      return {bus.addr_valid, bus.neuron_finished, bus.layer_finished, bus.alu_rst,
              bus.busy, bus.done, bus.ip, bus.neuro_read_addr, bus.weight_read_addr,
              bus.neuro_write_addr};
   endfunction

   // Expected cycle-by-cycle trace from the FETCH cycle until the HALT cycle.
   task automatic build_trace();
      bit [7:0] rd, wr, wt, n_in, n_out;
      exp_q.delete();
      rd = 8'd0;
      wt = 8'd0;
      wr = prog[0][7:0];
      for (int p = 0; p < 16; p++) begin
         exp_q.push_back(rec(0, 0, 0, 1, 1, 0, 4'(p), 0, 0, 0));
         n_in  = prog[p][7:0];
         n_out = prog[p][15:8];
         if (n_in == 0 || n_out == 0) begin
            exp_q.push_back(rec(0, 0, 0, 1, 0, 1, 4'(p), 0, 0, 0));
            return;
         end
         for (int j = 0; j < n_out; j++)
            for (int i = 0; i < n_in; i++) begin
               exp_q.push_back(rec(1, i == n_in - 1, (i == n_in - 1) && (j == n_out - 1),
                                   0, 1, 0, 4'(p), 8'(rd + i), wt, 8'(wr + j)));
               wt = wt + 8'd1;
            end
         rd = wr;
         wr = wr + n_out;
      end
      exp_q.push_back(rec(0, 0, 0, 1, 0, 1, 4'd15, 0, 0, 0));
   endtask

   task automatic load_prog();
      for (int p = 0; p < 16; p++) begin
         @(negedge clk);
         bus.instr_we    = 1'b1;
         bus.instr_waddr = 4'(p);
         bus.instr_wdata = prog[p];
      end
      @(negedge clk);
      bus.instr_we = 1'b0;
   endtask

   // Start the loaded program and compare the full trace. inject pulses start
   // while busy; poke rewrites instr[0] on the FETCH of layer 0.
   task automatic run_trace(input string name, input bit inject, input bit poke,
                            input logic [15:0] poke_word);
      build_trace();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
         check($sformatf("%s cyc%0d", name, k), observe(), exp_q[k]);
         bus.start = inject && (k < exp_q.size() - 1) && ($urandom_range(0, 2) == 0);
         if (poke && k == 0) begin
            bus.instr_we    = 1'b1;
            bus.instr_waddr = 4'd0;
            bus.instr_wdata = poke_word;
         end
         @(negedge clk);
         bus.instr_we = 1'b0;
      end
      bus.start = 1'b0;
      if (poke) prog[0] = poke_word;
   endtask

   task automatic clear_prog();
      for (int p = 0; p < 16; p++) prog[p] = 16'h0000;
   endtask

   initial begin
      logic [33:0] idle_rec;
      idle_rec        = rec(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0);
      reset           = 1'b1;
      bus.start       = 1'b0;
      bus.instr_we    = 1'b0;
      bus.instr_waddr = '0;
      bus.instr_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", observe(), idle_rec);
      reset = 1'b0;
      @(negedge clk);
      check("idle_after_reset", observe(), idle_rec);

      // Two-neuron, three-input layer, then terminator; start pulses ignored.
      clear_prog();
      prog[0] = 16'h0203;
      load_prog();
      run_trace("single_layer", 1'b1, 1'b0, 16'h0);

      // Two layers chained through the neuron RAM.
      prog[1] = 16'h0102;
      load_prog();
      run_trace("two_layers", 1'b0, 1'b0, 16'h0);

      // Abort on RUN cycle 4 (reset and start together), then replay.
      clear_prog();
      prog[0] = 16'h0203;
      load_prog();
      build_trace();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         check($sformatf("abort cyc%0d", k), observe(), exp_q[k]);
         if (k < 4) @(negedge clk);
      end
      reset     = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      check("abort_idle", observe(), idle_rec);
      reset     = 1'b0;
      bus.start = 1'b0;
      run_trace("replay", 1'b0, 1'b0, 16'h0);

      // Empty first instruction: FETCH then HALT, never valid.
      prog[0] = 16'h0000;
      load_prog();
      run_trace("empty", 1'b1, 1'b0, 16'h0);

      // Sixteen single-cycle layers: ip saturates at 15.
      for (int p = 0; p < 16; p++) prog[p] = 16'h0101;
      load_prog();
      run_trace("full_ip", 1'b1, 1'b0, 16'h0);

      // Address wrap: long layers push weight and write bases past 255.
      clear_prog();
      prog[0] = 16'h0450;
      prog[1] = 16'hC002;
      load_prog();
      run_trace("wrap", 1'b0, 1'b0, 16'h0);

      // Randomized programs; one rewrites instr[0] during its own fetch.
      for (int r = 0; r < 10; r++) begin
         for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 11) == 0) prog[p] = 16'h0000;
            else prog[p] = {8'($urandom_range(1, 4)), 8'($urandom_range(1, 4))};
         end
         prog[0] = {8'($urandom_range(1, 4)), 8'($urandom_range(1, 4))};
         load_prog();
         run_trace($sformatf("rand%0d", r), r[0], r == 3, 16'h0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
